// File: rtl/ccff_shadow_bank.sv
// Configuration-memory bank: a serial shadow chain loaded bit by bit, and an
// active register that the fabric sees. The active register changes only on an
// accepted commit, so the fabric never sees a half-shifted configuration.
module ccff_shadow_bank #(
  parameter int NUM_BITS   = 32,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit STRICT_LEN = 1'b1,
  localparam int CW        = $clog2(NUM_BITS + 1)
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                ccff_head,
  input  logic                shift_en,
  input  logic                commit,
  input  logic                clear_cnt,
  input  logic                commit_parity,
  output logic                ccff_tail,
  output logic [NUM_BITS-1:0] mem_out,
  output logic [NUM_BITS-1:0] mem_outb,
  output logic [CW-1:0]       bit_cnt,
  output logic                overshift,
  output logic                commit_ok,
  output logic                commit_err
);

  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_BITS);

  logic [NUM_BITS-1:0] r_shadow;
  logic [NUM_BITS-1:0] r_active;
  logic [CW-1:0]       r_cnt;
  logic                r_over;
  logic                r_par;
  logic                r_ok;
  logic                r_err;

  logic w_full;
  logic w_len_ok;
  logic w_par_ok;
  logic w_accept;
  logic w_reject;

  // Acceptance is judged on the pre-clear state; a commit that collides with
  // a shift is always refused because the shadow is moving under it.
  always_comb begin
    w_full   = (r_cnt == FULL_CNT);
    w_len_ok = !STRICT_LEN || (w_full && !r_over);
    w_par_ok = !PARITY_EN || (r_par == commit_parity);
    w_accept = commit && !shift_en && w_len_ok && w_par_ok;
    w_reject = commit && !w_accept;
  end

  // Shadow chain: keeps shifting even past NUM_BITS so cascaded banks load.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n)
      r_shadow <= '0;
    else if (shift_en)
      r_shadow <= {r_shadow[NUM_BITS-2:0], ccff_head};
  end

  // Active bits: copied from the shadow only on an accepted commit.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n)
      r_active <= '0;
    else if (w_accept)
      r_active <= r_shadow;
  end

  // Bit counter, sticky overshift and running parity; clear and accepted
  // commit both take priority over a simultaneous shift.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_cnt  <= '0;
      r_over <= 1'b0;
      r_par  <= 1'b0;
    end else if (w_accept || clear_cnt) begin
      r_cnt  <= '0;
      r_over <= 1'b0;
      r_par  <= 1'b0;
    end else if (shift_en) begin
      r_par <= r_par ^ ccff_head;
      if (w_full)
        r_over <= 1'b1;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // One-cycle result pulses, registered off the commit edge.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_ok  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ok  <= w_accept;
      r_err <= w_reject;
    end
  end

  assign ccff_tail  = r_shadow[NUM_BITS-1];
  assign mem_out    = r_active;
  assign mem_outb   = ~r_active;
  assign bit_cnt    = r_cnt;
  assign overshift  = r_over;
  assign commit_ok  = r_ok;
  assign commit_err = r_err;

endmodule

// File: tb/tb_ccff_shadow_bank.sv
// Directed bench: a strict/parity-checked bank (dut) and a permissive bank
// (dut2, no length or parity check) share the same stimulus.
module tb_ccff_shadow_bank;

  logic        clk;
  logic        rst_n;
  logic        head;
  logic        shift_en;
  logic        commit;
  logic        clear_cnt;
  logic        cpar;

  logic        tail,  tail2;
  logic [31:0] mout,  mout2;
  logic [31:0] moutb, moutb2;
  logic [5:0]  cnt,   cnt2;
  logic        over,  over2;
  logic        ok,    ok2;
  logic        err,   err2;

  int total = 0;
  int bad   = 0;

  ccff_shadow_bank #(.NUM_BITS(32), .PARITY_EN(1'b1), .STRICT_LEN(1'b1)) dut (
    .prog_clk(clk), .prog_reset_n(rst_n), .ccff_head(head), .shift_en(shift_en),
    .commit(commit), .clear_cnt(clear_cnt), .commit_parity(cpar),
    .ccff_tail(tail), .mem_out(mout), .mem_outb(moutb), .bit_cnt(cnt),
    .overshift(over), .commit_ok(ok), .commit_err(err)
  );

  ccff_shadow_bank #(.NUM_BITS(32), .PARITY_EN(1'b0), .STRICT_LEN(1'b0)) dut2 (
    .prog_clk(clk), .prog_reset_n(rst_n), .ccff_head(head), .shift_en(shift_en),
    .commit(commit), .clear_cnt(clear_cnt), .commit_parity(cpar),
    .ccff_tail(tail2), .mem_out(mout2), .mem_outb(moutb2), .bit_cnt(cnt2),
    .overshift(over2), .commit_ok(ok2), .commit_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift the low n bits of d, MSB first.
  task automatic shift_bits(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      head     = d[i];
      shift_en = 1'b1;
      step();
    end
    shift_en = 1'b0;
    head     = 1'b0;
  endtask

  task automatic do_commit(input logic p);
    commit = 1'b1;
    cpar   = p;
    step();
    commit = 1'b0;
    cpar   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; head = 1'b0; shift_en = 1'b0; commit = 1'b0;
    clear_cnt = 1'b0; cpar = 1'b0;
    #12;
    chk("rst_mem_out",  mout, 32'h0);
    chk("rst_mem_outb", moutb, 32'hFFFF_FFFF);
    chk("rst_bit_cnt",  32'(cnt), 32'd0);
    chk("rst_ok_err",   {30'd0, ok, err}, 32'd0);
    chk("rst_tail_ovr", {30'd0, tail, over}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Good load and commit, even parity.
    shift_bits(32'hA5A5_F00F, 32);
    chk("load_cnt32", 32'(cnt), 32'd32);
    chk("load_tail_msb", 32'(tail), 32'd1);
    do_commit(1'b0);
    chk("c1_mem_out",  mout, 32'hA5A5_F00F);
    chk("c1_mem_outb", moutb, 32'h5A5A_0FF0);
    chk("c1_ok_err",   {30'd0, ok, err}, 32'b10);
    chk("c1_cnt_clr",  32'(cnt), 32'd0);
    step();
    chk("c1_ok_pulse_end", 32'(ok), 32'd0);

    // Odd-parity load, wrong then right parity.
    shift_bits(32'h1234_5678, 32);
    do_commit(1'b0);
    chk("par_err",      {30'd0, ok, err}, 32'b01);
    chk("par_mem_keep", mout, 32'hA5A5_F00F);
    chk("par_cnt_keep", 32'(cnt), 32'd32);
    do_commit(1'b1);
    chk("par_ok",       {30'd0, ok, err}, 32'b10);
    chk("par_mem_new",  mout, 32'h1234_5678);

    // Overshift: 33 bits, commit refused even with matching parity.
    shift_bits(32'hDEAD_BEEF, 32);
    chk("ovr_tail32",  32'(tail), 32'd1);
    chk("ovr_flag0",   32'(over), 32'd0);
    shift_bits(32'h1, 1);
    chk("ovr_flag1",   32'(over), 32'd1);
    chk("ovr_cnt_sat", 32'(cnt), 32'd32);
    do_commit(1'b1);
    chk("ovr_err",      {30'd0, ok, err}, 32'b01);
    chk("ovr_mem_keep", mout, 32'h1234_5678);
    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
    chk("clr_cnt",  32'(cnt), 32'd0);
    chk("clr_over", 32'(over), 32'd0);
    shift_bits(32'h0F0F_0F01, 32);
    do_commit(1'b1);
    chk("reload_ok",  {30'd0, ok, err}, 32'b10);
    chk("reload_mem", mout, 32'h0F0F_0F01);

    // Short load: strict bank refuses, permissive bank takes the shadow.
    shift_bits(32'h000A_BCDE, 20);
    do_commit(1'b1);
    chk("short_err",      {30'd0, ok, err}, 32'b01);
    chk("short_cnt",      32'(cnt), 32'd20);
    chk("short_mem_keep", mout, 32'h0F0F_0F01);
    chk("lax_ok",         {30'd0, ok2, err2}, 32'b10);
    chk("lax_mem",        mout2, 32'hF01A_BCDE);
    chk("lax_mem_b",      moutb2, 32'h0FE5_4321);

    // Commit colliding with a shift: refused, shift still happens.
    head = 1'b1; shift_en = 1'b1; commit = 1'b1; cpar = 1'b0;
    step();
    head = 1'b0; shift_en = 1'b0; commit = 1'b0;
    chk("coll_err",      {30'd0, ok, err}, 32'b01);
    chk("coll_cnt",      32'(cnt), 32'd21);
    chk("coll_mem_keep", mout, 32'h0F0F_0F01);
    chk("coll_lax_err",  {30'd0, ok2, err2}, 32'b01);
    chk("coll_lax_keep", mout2, 32'hF01A_BCDE);
    do_commit(1'b0);
    chk("coll_lax_shifted", mout2, 32'hE035_79BD);

    // Asynchronous reset between edges after a good commit.
    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
    shift_bits(32'hA5A5_F00F, 32);
    do_commit(1'b0);
    chk("pre_rst_mem", mout, 32'hA5A5_F00F);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_out",  mout, 32'h0);
    chk("arst_mem_outb", moutb, 32'hFFFF_FFFF);
    chk("arst_cnt",      32'(cnt), 32'd0);
    chk("arst_ok_tail",  {30'd0, ok, tail}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
